// File: rtl/multicycle_ctrl.sv
// Sequencing controller for the multi-cycle 32-bit datapath.
// Steps each instruction through IF/ID/EX/MEM/WB and decodes every datapath control from the state.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IF   | fetch: read IM into IR, latch PC+4 into NPC
// S_ID   | decode: read register file into A/B, load Imm, PC <= NPC
// S_EX   | execute: ALU op, address add or branch-target add
// S_MEM  | data memory access (LD/ST) or taken-branch PC write
// S_WB   | register file write-back
// S_HALT | absorbing stop; only rst leaves it
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [3:0] func,
    input  logic       sign,
    output logic       LoadPC,
    output logic       PCSel,
    output logic       ReadIM,
    output logic       LoadNPC,
    output logic       LoadIR,
    output logic       ReadRP1,
    output logic       ReadRP2,
    output logic       WriteRP,
    output logic       LoadA,
    output logic       LoadB,
    output logic       IMMsel,
    output logic       LoadIMM,
    output logic       MUXALU1,
    output logic       MUXALU2,
    output logic       LoadALUOut,
    output logic       ReadDM,
    output logic       WriteDM,
    output logic       LoadLMD,
    output logic       MUXWB,
    output logic [3:0] ALUFunc,
    output logic [1:0] MUXMOVE,
    output logic       halted,
    output logic       illegal
);

    localparam logic [3:0] ALU_ADD = 4'b0000;

    localparam logic [5:0] OP_ALUR = 6'b000000;
    localparam logic [5:0] OP_ALUI = 6'b000001;
    localparam logic [5:0] OP_LD   = 6'b000010;
    localparam logic [5:0] OP_ST   = 6'b000011;
    localparam logic [5:0] OP_BR   = 6'b000100;
    localparam logic [5:0] OP_BMI  = 6'b000101;
    localparam logic [5:0] OP_BPL  = 6'b000110;
    localparam logic [5:0] OP_MOV  = 6'b000111;
    localparam logic [5:0] OP_CMOV = 6'b001000;
    localparam logic [5:0] OP_LDI  = 6'b001001;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic is_alu, is_ld, is_st, is_br, is_halt, is_legal, br_taken, uses_mem;

    assign is_alu   = (opcode == OP_ALUR) || (opcode == OP_ALUI);
    assign is_ld    = (opcode == OP_LD);
    assign is_st    = (opcode == OP_ST);
    assign is_br    = (opcode == OP_BR) || (opcode == OP_BMI) || (opcode == OP_BPL);
    assign is_halt  = (opcode == OP_HALT);
    assign is_legal = (opcode <= OP_LDI);
    assign uses_mem = is_ld || is_st || is_br;
    assign br_taken = (opcode == OP_BR) || ((opcode == OP_BMI) && sign) ||
                      ((opcode == OP_BPL) && !sign);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:   state_d = S_ID;
            S_ID: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (!is_legal) begin
                    state_d = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX:   state_d = uses_mem ? S_MEM : S_WB;
            S_MEM:  state_d = is_ld ? S_WB : S_IF;
            S_WB:   state_d = S_IF;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Everything is forced low while rst is held, including the IF decode.
    always_comb begin
        LoadPC     = 1'b0;
        PCSel      = 1'b0;
        ReadIM     = 1'b0;
        LoadNPC    = 1'b0;
        LoadIR     = 1'b0;
        ReadRP1    = 1'b0;
        ReadRP2    = 1'b0;
        WriteRP    = 1'b0;
        LoadA      = 1'b0;
        LoadB      = 1'b0;
        IMMsel     = 1'b0;
        LoadIMM    = 1'b0;
        MUXALU1    = 1'b0;
        MUXALU2    = 1'b0;
        LoadALUOut = 1'b0;
        ReadDM     = 1'b0;
        WriteDM    = 1'b0;
        LoadLMD    = 1'b0;
        MUXWB      = 1'b0;
        ALUFunc    = ALU_ADD;
        MUXMOVE    = 2'd0;
        halted     = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            IMMsel = 1'b1;
            case (state_q)
                S_IF: begin
                    ReadIM  = 1'b1;
                    LoadIR  = 1'b1;
                    LoadNPC = 1'b1;
                end
                S_ID: begin
                    ReadRP1 = 1'b1;
                    ReadRP2 = 1'b1;
                    LoadA   = 1'b1;
                    LoadB   = 1'b1;
                    LoadIMM = 1'b1;
                    LoadPC  = 1'b1;
                    IMMsel  = !is_br;
                    illegal = !is_legal && !is_halt;
                end
                S_EX: begin
                    if (is_alu) begin
                        MUXALU2    = (opcode == OP_ALUI);
                        ALUFunc    = func;
                        LoadALUOut = 1'b1;
                    end else if (is_ld || is_st) begin
                        MUXALU2    = 1'b1;
                        LoadALUOut = 1'b1;
                    end else if (is_br) begin
                        MUXALU1    = 1'b1;
                        MUXALU2    = 1'b1;
                        LoadALUOut = 1'b1;
                    end
                end
                S_MEM: begin
                    if (is_ld) begin
                        ReadDM  = 1'b1;
                        LoadLMD = 1'b1;
                    end else if (is_st) begin
                        WriteDM = 1'b1;
                    end else if (is_br && br_taken) begin
                        LoadPC = 1'b1;
                        PCSel  = 1'b1;
                    end
                end
                S_WB: begin
                    WriteRP = 1'b1;
                    if (is_alu) begin
                        MUXWB = 1'b1;
                    end else if (opcode == OP_MOV) begin
                        MUXMOVE = 2'd2;
                    end else if (opcode == OP_CMOV) begin
                        MUXMOVE = 2'd1;
                    end else if (opcode == OP_LDI) begin
                        MUXMOVE = 2'd3;
                    end
                end
                S_HALT: begin
                    IMMsel = 1'b0;
                    halted = 1'b1;
                end
                default: IMMsel = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: per-cycle expected control words are queued
// per instruction and popped against the DUT outputs at each falling edge.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic LoadPC, PCSel, ReadIM, LoadNPC, LoadIR, ReadRP1, ReadRP2, WriteRP;
        logic LoadA, LoadB, IMMsel, LoadIMM, MUXALU1, MUXALU2, LoadALUOut;
        logic ReadDM, WriteDM, LoadLMD, MUXWB;
        logic [3:0] ALUFunc;
        logic [1:0] MUXMOVE;
        logic halted, illegal;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [3:0] func = 4'd0;
    logic       sign = 1'b0;

    logic LoadPC, PCSel, ReadIM, LoadNPC, LoadIR, ReadRP1, ReadRP2, WriteRP;
    logic LoadA, LoadB, IMMsel, LoadIMM, MUXALU1, MUXALU2, LoadALUOut;
    logic ReadDM, WriteDM, LoadLMD, MUXWB, halted, illegal;
    logic [3:0] ALUFunc;
    logic [1:0] MUXMOVE;

    ctl_t obs;
    ctl_t exp_q[$];
    string tag_q[$];
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .sign(sign),
        .LoadPC(LoadPC), .PCSel(PCSel), .ReadIM(ReadIM), .LoadNPC(LoadNPC), .LoadIR(LoadIR),
        .ReadRP1(ReadRP1), .ReadRP2(ReadRP2), .WriteRP(WriteRP), .LoadA(LoadA), .LoadB(LoadB),
        .IMMsel(IMMsel), .LoadIMM(LoadIMM), .MUXALU1(MUXALU1), .MUXALU2(MUXALU2),
        .LoadALUOut(LoadALUOut), .ReadDM(ReadDM), .WriteDM(WriteDM), .LoadLMD(LoadLMD),
        .MUXWB(MUXWB), .ALUFunc(ALUFunc), .MUXMOVE(MUXMOVE), .halted(halted), .illegal(illegal)
    );

    assign obs = {LoadPC, PCSel, ReadIM, LoadNPC, LoadIR, ReadRP1, ReadRP2, WriteRP,
                  LoadA, LoadB, IMMsel, LoadIMM, MUXALU1, MUXALU2, LoadALUOut,
                  ReadDM, WriteDM, LoadLMD, MUXWB, ALUFunc, MUXMOVE, halted, illegal};

    function automatic ctl_t e_base();
        ctl_t c = '0;
        c.IMMsel = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_if();
        ctl_t c = e_base();
        c.ReadIM = 1'b1; c.LoadIR = 1'b1; c.LoadNPC = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_id(logic immsel, logic ill);
        ctl_t c = e_base();
        c.ReadRP1 = 1'b1; c.ReadRP2 = 1'b1; c.LoadA = 1'b1; c.LoadB = 1'b1;
        c.LoadIMM = 1'b1; c.LoadPC = 1'b1; c.IMMsel = immsel; c.illegal = ill;
        return c;
    endfunction

    function automatic ctl_t e_ex(logic m1, logic m2, logic [3:0] fn, logic ld_alu);
        ctl_t c = e_base();
        c.MUXALU1 = m1; c.MUXALU2 = m2; c.ALUFunc = fn; c.LoadALUOut = ld_alu;
        return c;
    endfunction

    function automatic ctl_t e_mem(logic rd, logic wr, logic pc);
        ctl_t c = e_base();
        c.ReadDM = rd; c.LoadLMD = rd; c.WriteDM = wr; c.LoadPC = pc; c.PCSel = pc;
        return c;
    endfunction

    function automatic ctl_t e_wb(logic muxwb, logic [1:0] mv);
        ctl_t c = e_base();
        c.WriteRP = 1'b1; c.MUXWB = muxwb; c.MUXMOVE = mv;
        return c;
    endfunction

    function automatic ctl_t e_halt();
        ctl_t c = '0;
        c.halted = 1'b1;
        return c;
    endfunction

    task automatic push(input ctl_t c, input string tag);
        exp_q.push_back(c);
        tag_q.push_back(tag);
    endtask

    // Pops and compares one queued word per cycle; returns at posedge+1 of the following cycle.
    task automatic run_queue();
        ctl_t  e;
        string t;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_assert++;
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input logic [5:0] op, input logic [3:0] fn, input logic sg);
        opcode = op; func = fn; sign = sg;
    endtask

    initial begin
        // Reset: all outputs zero while rst is high.
        for (int i = 0; i < 3; i++) push('0, "reset");
        run_queue();
        rst = 1'b0;

        // ALU-R, func 0011: IF ID EX WB, ALUFunc only in EX, WriteRP in cycle 4.
        set_in(6'b000000, 4'b0011, 1'b0);
        push(e_if(), "alur_if"); push(e_id(1'b1, 1'b0), "alur_id");
        push(e_ex(1'b0, 1'b0, 4'b0011, 1'b1), "alur_ex"); push(e_wb(1'b1, 2'd0), "alur_wb");
        run_queue();

        set_in(6'b000001, 4'b0101, 1'b1);
        push(e_if(), "alui_if"); push(e_id(1'b1, 1'b0), "alui_id");
        push(e_ex(1'b0, 1'b1, 4'b0101, 1'b1), "alui_ex"); push(e_wb(1'b1, 2'd0), "alui_wb");
        run_queue();

        // LD then ST back-to-back.
        set_in(6'b000010, 4'b1111, 1'b0);
        push(e_if(), "ld_if"); push(e_id(1'b1, 1'b0), "ld_id");
        push(e_ex(1'b0, 1'b1, 4'b0000, 1'b1), "ld_ex"); push(e_mem(1'b1, 1'b0, 1'b0), "ld_mem");
        push(e_wb(1'b0, 2'd0), "ld_wb");
        run_queue();
        set_in(6'b000011, 4'b1010, 1'b1);
        push(e_if(), "st_if"); push(e_id(1'b1, 1'b0), "st_id");
        push(e_ex(1'b0, 1'b1, 4'b0000, 1'b1), "st_ex"); push(e_mem(1'b0, 1'b1, 1'b0), "st_mem");
        run_queue();

        // Branches: BMI taken/not, BPL not/taken, BR always taken.
        set_in(6'b000101, 4'b0000, 1'b1);
        push(e_if(), "bmi1_if"); push(e_id(1'b0, 1'b0), "bmi1_id");
        push(e_ex(1'b1, 1'b1, 4'b0000, 1'b1), "bmi1_ex"); push(e_mem(1'b0, 1'b0, 1'b1), "bmi1_mem");
        run_queue();
        set_in(6'b000101, 4'b0000, 1'b0);
        push(e_if(), "bmi0_if"); push(e_id(1'b0, 1'b0), "bmi0_id");
        push(e_ex(1'b1, 1'b1, 4'b0000, 1'b1), "bmi0_ex"); push(e_mem(1'b0, 1'b0, 1'b0), "bmi0_mem");
        run_queue();
        set_in(6'b000110, 4'b0000, 1'b1);
        push(e_if(), "bpl1_if"); push(e_id(1'b0, 1'b0), "bpl1_id");
        push(e_ex(1'b1, 1'b1, 4'b0000, 1'b1), "bpl1_ex"); push(e_mem(1'b0, 1'b0, 1'b0), "bpl1_mem");
        run_queue();
        set_in(6'b000110, 4'b0000, 1'b0);
        push(e_if(), "bpl0_if"); push(e_id(1'b0, 1'b0), "bpl0_id");
        push(e_ex(1'b1, 1'b1, 4'b0000, 1'b1), "bpl0_ex"); push(e_mem(1'b0, 1'b0, 1'b1), "bpl0_mem");
        run_queue();
        set_in(6'b000100, 4'b0000, 1'b1);
        push(e_if(), "br_if"); push(e_id(1'b0, 1'b0), "br_id");
        push(e_ex(1'b1, 1'b1, 4'b0000, 1'b1), "br_ex"); push(e_mem(1'b0, 1'b0, 1'b1), "br_mem");
        run_queue();

        // MOV, CMOV, LDI: EX idle, WB selects MUXMOVE 2/1/3.
        set_in(6'b000111, 4'b0110, 1'b0);
        push(e_if(), "mov_if"); push(e_id(1'b1, 1'b0), "mov_id");
        push(e_base(), "mov_ex"); push(e_wb(1'b0, 2'd2), "mov_wb");
        run_queue();
        set_in(6'b001000, 4'b0110, 1'b1);
        push(e_if(), "cmov_if"); push(e_id(1'b1, 1'b0), "cmov_id");
        push(e_base(), "cmov_ex"); push(e_wb(1'b0, 2'd1), "cmov_wb");
        run_queue();
        set_in(6'b001001, 4'b0110, 1'b0);
        push(e_if(), "ldi_if"); push(e_id(1'b1, 1'b0), "ldi_id");
        push(e_base(), "ldi_ex"); push(e_wb(1'b0, 2'd3), "ldi_wb");
        run_queue();

        // Undefined opcode: illegal pulse in ID, then straight back to IF.
        set_in(6'b010101, 4'b0000, 1'b0);
        push(e_if(), "ill_if"); push(e_id(1'b1, 1'b1), "ill_id");
        run_queue();
        set_in(6'b000000, 4'b0111, 1'b0);
        push(e_if(), "postill_if"); push(e_id(1'b1, 1'b0), "postill_id");
        push(e_ex(1'b0, 1'b0, 4'b0111, 1'b1), "postill_ex"); push(e_wb(1'b1, 2'd0), "postill_wb");
        run_queue();

        // Reset during LD MEM: that cycle all zero, then a fresh fetch.
        set_in(6'b000010, 4'b0000, 1'b0);
        push(e_if(), "ldrst_if"); push(e_id(1'b1, 1'b0), "ldrst_id");
        push(e_ex(1'b0, 1'b1, 4'b0000, 1'b1), "ldrst_ex");
        run_queue();
        rst = 1'b1;
        push('0, "ldrst_mem");
        run_queue();
        rst = 1'b0;
        set_in(6'b000000, 4'b1001, 1'b0);
        push(e_if(), "afterrst_if"); push(e_id(1'b1, 1'b0), "afterrst_id");
        push(e_ex(1'b0, 1'b0, 4'b1001, 1'b1), "afterrst_ex"); push(e_wb(1'b1, 2'd0), "afterrst_wb");
        run_queue();

        // HALT: absorbing for 20 cycles regardless of inputs, only rst exits.
        set_in(6'b111111, 4'b0000, 1'b0);
        push(e_if(), "halt_if"); push(e_id(1'b1, 1'b0), "halt_id");
        run_queue();
        set_in(6'b000000, 4'b0011, 1'b1);
        for (int i = 0; i < 20; i++) push(e_halt(), "halt_hold");
        run_queue();
        rst = 1'b1;
        push('0, "halt_rst");
        run_queue();
        rst = 1'b0;
        set_in(6'b000111, 4'b0000, 1'b0);
        push(e_if(), "posthalt_if"); push(e_id(1'b1, 1'b0), "posthalt_id");
        push(e_base(), "posthalt_ex"); push(e_wb(1'b0, 2'd2), "posthalt_wb");
        run_queue();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
